// File: rtl/drowsiness_alarm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drowsy_pkg
//  Brief    : Shared class / alert-state encodings and score scale for the
//             ANN detector, the drowsiness alarm controller and the bench.
//  Revision : 1.0  initial release
// ============================================================================
package drowsy_pkg;

    typedef enum logic [1:0] {
        CLS_ALERT    = 2'd0,
        CLS_FATIGUED = 2'd1,
        CLS_DROWSY   = 2'd2,
        CLS_UNKNOWN  = 2'd3
    } class_e;

    typedef enum logic [1:0] {
        ST_ALERT = 2'd0,
        ST_WARN  = 2'd1,
        ST_ALARM = 2'd2,
        ST_HOLD  = 2'd3
    } alert_state_e;

    // Full-scale score: 1000 represents 1.0
    localparam int SCORE_FULL = 1000;

endpackage
`default_nettype wire

// File: rtl/drowsiness_alarm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : drowsiness_alarm_ctrl_if
//  Brief    : Frame input / warning output bundle between the ANN stage,
//             the driver console and the drowsiness alarm controller.
//  Revision : 1.0  initial release
// ============================================================================
interface drowsiness_alarm_ctrl_if #(
    parameter int W   = 10,
    parameter int WIN = 8
);
    import drowsy_pkg::*;

    logic                        clear;
    logic                        alarm_ack;
    logic                        done;
    logic [2:0][W-1:0]           out_ann;

    class_e                      class_out;
    logic                        class_valid;
    logic [$clog2(WIN+1)-1:0]    drowsy_cnt;
    alert_state_e                state;
    logic                        warn;
    logic                        alarm;
    logic                        fault;

    modport master (
        output clear, alarm_ack, done, out_ann,
        input  class_out, class_valid, drowsy_cnt, state, warn, alarm, fault
    );

    modport slave (
        input  clear, alarm_ack, done, out_ann,
        output class_out, class_valid, drowsy_cnt, state, warn, alarm, fault
    );

endinterface
`default_nettype wire

// File: rtl/drowsiness_alarm_ctrl_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : ann_argmax
//  Brief    : Combinational argmax over three ANN scores with confidence gate;
//             ties go to the higher index so drowsy wins any tie.
//  Revision : 1.0  initial release
// ============================================================================
module ann_argmax
    import drowsy_pkg::*;
#(
    parameter int W        = 10,
    parameter int CONF_MIN = 600
) (
    input  wire logic [2:0][W-1:0] i_scores,
    output class_e                 o_class
);

    localparam logic [W-1:0] c_conf_min = W'(CONF_MIN);

    class_e         w_idx;
    logic [W-1:0]   w_max;

    always_comb begin
        w_idx = CLS_ALERT;
        w_max = i_scores[0];
        if (i_scores[2] >= i_scores[1] && i_scores[2] >= i_scores[0]) begin
            w_idx = CLS_DROWSY;
            w_max = i_scores[2];
        end else if (i_scores[1] >= i_scores[0]) begin
            w_idx = CLS_FATIGUED;
            w_max = i_scores[1];
        end
        o_class = (w_max < c_conf_min) ? CLS_UNKNOWN : w_idx;
    end

endmodule
`default_nettype wire

// File: rtl/drowsiness_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : drowsiness_alarm_ctrl
//  Brief    : Classifies each ANN result, keeps a sliding window of frame
//             classes and drives warn/alarm through a hysteresis + hold FSM.
//  Revision : 1.0  initial release
// ============================================================================
module drowsiness_alarm_ctrl
    import drowsy_pkg::*;
#(
    parameter int W        = 10,
    parameter int WIN      = 8,
    parameter int CONF_MIN = 600,
    parameter int WARN_TH  = 3,
    parameter int ALARM_TH = 5,
    parameter int CLR_TH   = 1,
    parameter int HOLD_CYC = 1000,
    parameter int UNK_MAX  = 4
) (
    input  wire logic               Clock,
    input  wire logic               Rst,
    drowsiness_alarm_ctrl_if.slave  bus
);

    localparam int c_cnt_w = $clog2(WIN + 1);
    localparam int c_unk_w = $clog2(UNK_MAX + 1);
    localparam int c_tmr_w = $clog2(HOLD_CYC + 1);

    localparam logic [c_cnt_w-1:0] c_warn_th  = c_cnt_w'(WARN_TH);
    localparam logic [c_cnt_w-1:0] c_alarm_th = c_cnt_w'(ALARM_TH);
    localparam logic [c_cnt_w-1:0] c_clr_th   = c_cnt_w'(CLR_TH);
    localparam logic [c_unk_w-1:0] c_unk_max  = c_unk_w'(UNK_MAX);
    localparam logic [c_tmr_w-1:0] c_hold_ld  = c_tmr_w'(HOLD_CYC - 1);

    logic                 r_done_q;
    logic                 w_acc;
    class_e               w_cls;
    class_e               r_win [WIN];
    class_e               r_class;
    logic                 r_valid;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_unk_w-1:0]   r_unk;
    logic [c_unk_w-1:0]   w_unk_nxt;
    logic                 r_fault;
    alert_state_e         r_state;
    alert_state_e         w_state_nxt;
    logic [c_tmr_w-1:0]   r_tmr;
    logic [c_tmr_w-1:0]   w_tmr_nxt;

    ann_argmax #(
        .W        (W),
        .CONF_MIN (CONF_MIN)
    ) u_argmax (
        .i_scores (bus.out_ann),
        .o_class  (w_cls)
    );

    assign w_acc = bus.done & ~r_done_q;

    // Window count moves by at most one per frame, so it stays within 0..WIN
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_cls == CLS_DROWSY)
            w_cnt_nxt = w_cnt_nxt + c_cnt_w'(1);
        if (r_win[WIN-1] == CLS_DROWSY)
            w_cnt_nxt = w_cnt_nxt - c_cnt_w'(1);

        w_unk_nxt = '0;
        if (w_cls == CLS_UNKNOWN)
            w_unk_nxt = (r_unk == c_unk_max) ? r_unk : r_unk + c_unk_w'(1);
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_done_q <= 1'b0;
            r_valid  <= 1'b0;
            r_class  <= CLS_ALERT;
            r_cnt    <= '0;
            r_unk    <= '0;
            r_fault  <= 1'b0;
            for (int i = 0; i < WIN; i++)
                r_win[i] <= CLS_ALERT;
        end else begin
            r_done_q <= bus.done;
            r_valid  <= w_acc & ~bus.clear;
            if (bus.clear) begin
                r_cnt   <= '0;
                r_unk   <= '0;
                r_fault <= 1'b0;
                for (int i = 0; i < WIN; i++)
                    r_win[i] <= CLS_ALERT;
            end else if (w_acc) begin
                r_class  <= w_cls;
                r_cnt    <= w_cnt_nxt;
                r_unk    <= w_unk_nxt;
                r_fault  <= r_fault | (w_unk_nxt == c_unk_max);
                r_win[0] <= w_cls;
                for (int i = 1; i < WIN; i++)
                    r_win[i] <= r_win[i-1];
            end
        end
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_ALERT;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // FSM runs on the registered count, one clock behind the window update
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        if (bus.clear) begin
            w_state_nxt = ST_ALERT;
            w_tmr_nxt   = '0;
        end else begin
            case (r_state)
                ST_ALERT: begin
                    if (r_cnt >= c_alarm_th)
                        w_state_nxt = ST_ALARM;
                    else if (r_cnt >= c_warn_th)
                        w_state_nxt = ST_WARN;
                end
                ST_WARN: begin
                    if (r_cnt >= c_alarm_th)
                        w_state_nxt = ST_ALARM;
                    else if (r_cnt < c_clr_th)
                        w_state_nxt = ST_ALERT;
                end
                ST_ALARM: begin
                    if (r_cnt < c_clr_th) begin
                        w_state_nxt = ST_HOLD;
                        w_tmr_nxt   = c_hold_ld;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt >= c_alarm_th)
                        w_state_nxt = ST_ALARM;
                    else if (bus.alarm_ack)
                        w_state_nxt = ST_ALERT;
                    else if (r_tmr == '0)
                        w_state_nxt = ST_ALERT;
                    else
                        w_tmr_nxt = r_tmr - c_tmr_w'(1);
                end
                default: w_state_nxt = ST_ALERT;
            endcase
        end
    end

    assign bus.class_out   = r_class;
    assign bus.class_valid = r_valid;
    assign bus.drowsy_cnt  = r_cnt;
    assign bus.state       = r_state;
    assign bus.warn        = (r_state == ST_WARN);
    assign bus.alarm       = (r_state == ST_ALARM) || (r_state == ST_HOLD);
    assign bus.fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_drowsiness_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drowsiness_alarm_ctrl
//  Brief    : Directed + randomized bench for drowsiness_alarm_ctrl against a
//             frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_drowsiness_alarm_ctrl;
    import drowsy_pkg::*;

    localparam int W        = 10;
    localparam int WIN      = 8;
    localparam int CONF_MIN = 600;
    localparam int WARN_TH  = 3;
    localparam int ALARM_TH = 5;
    localparam int CLR_TH   = 1;
    localparam int HOLD_CYC = 10;
    localparam int UNK_MAX  = 4;

    logic Clock = 1'b0;
    logic Rst   = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;

    drowsiness_alarm_ctrl_if #(.W(W), .WIN(WIN)) bus ();

    drowsiness_alarm_ctrl #(
        .W(W), .WIN(WIN), .CONF_MIN(CONF_MIN), .WARN_TH(WARN_TH),
        .ALARM_TH(ALARM_TH), .CLR_TH(CLR_TH), .HOLD_CYC(HOLD_CYC), .UNK_MAX(UNK_MAX)
    ) dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Reference model: frame history as a queue, count recomputed from it
    int m_win[$];
    int m_class, m_valid, m_cnt, m_state, m_tmr, m_unk, m_fault, m_done_q;

    function automatic int ref_class(input int s0, input int s1, input int s2);
        int s[3];
        int mx, idx;
        s[0] = s0; s[1] = s1; s[2] = s2;
        mx = s0;
        if (s1 > mx) mx = s1;
        if (s2 > mx) mx = s2;
        idx = 0;
        for (int i = 0; i < 3; i++)
            if (s[i] == mx) idx = i;
        return (mx < CONF_MIN) ? 3 : idx;
    endfunction

    task automatic model_flush();
        m_win = {};
        for (int i = 0; i < WIN; i++) m_win.push_back(0);
        m_cnt = 0; m_unk = 0; m_fault = 0;
    endtask

    always @(posedge Clock or posedge Rst) begin
        int acc, cls, n;
        if (Rst) begin
            model_flush();
            m_class = 0; m_valid = 0; m_state = ST_ALERT; m_tmr = 0; m_done_q = 0;
        end else begin
            acc      = (bus.done && !m_done_q) ? 1 : 0;
            m_done_q = bus.done;
            m_valid  = (acc == 1 && !bus.clear) ? 1 : 0;
            if (bus.clear) begin
                m_state = ST_ALERT; m_tmr = 0;
                model_flush();
            end else begin
                case (m_state)
                    ST_ALERT: if (m_cnt >= ALARM_TH) m_state = ST_ALARM;
                              else if (m_cnt >= WARN_TH) m_state = ST_WARN;
                    ST_WARN:  if (m_cnt >= ALARM_TH) m_state = ST_ALARM;
                              else if (m_cnt < CLR_TH) m_state = ST_ALERT;
                    ST_ALARM: if (m_cnt < CLR_TH) begin m_state = ST_HOLD; m_tmr = HOLD_CYC - 1; end
                    default: begin
                        if (m_cnt >= ALARM_TH) m_state = ST_ALARM;
                        else if (bus.alarm_ack) m_state = ST_ALERT;
                        else if (m_tmr == 0) m_state = ST_ALERT;
                        else m_tmr = m_tmr - 1;
                    end
                endcase
                if (acc == 1) begin
                    cls = ref_class(int'(bus.out_ann[0]), int'(bus.out_ann[1]), int'(bus.out_ann[2]));
                    m_class = cls;
                    m_win.push_front(cls);
                    void'(m_win.pop_back());
                    n = 0;
                    foreach (m_win[i]) if (m_win[i] == 2) n++;
                    m_cnt = n;
                    if (cls == 3) begin
                        if (m_unk < UNK_MAX) m_unk++;
                        if (m_unk == UNK_MAX) m_fault = 1;
                    end else begin
                        m_unk = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".class"},  32'(bus.class_out),   m_class);
        chk({ph, ".valid"},  32'(bus.class_valid), m_valid);
        chk({ph, ".cnt"},    32'(bus.drowsy_cnt),  m_cnt);
        chk({ph, ".state"},  32'(bus.state),       m_state);
        chk({ph, ".warn"},   32'(bus.warn),        (m_state == ST_WARN) ? 1 : 0);
        chk({ph, ".alarm"},  32'(bus.alarm),       (m_state == ST_ALARM || m_state == ST_HOLD) ? 1 : 0);
        chk({ph, ".fault"},  32'(bus.fault),       m_fault);
    endtask

    task automatic step(input int n, input string ph);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            check_all(ph);
            if (bus.class_valid === 1'b1) pulses++;
        end
    endtask

    task automatic set_scores(input int a, input int f, input int d);
        bus.out_ann[0] = a[W-1:0];
        bus.out_ann[1] = f[W-1:0];
        bus.out_ann[2] = d[W-1:0];
    endtask

    task automatic frame(input int a, input int f, input int d, input string ph);
        set_scores(a, f, d);
        bus.done = 1'b1;
        step(1, ph);
        bus.done = 1'b0;
        step(1, ph);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step(1, "clear");
        bus.clear = 1'b0;
        step(1, "clear");
    endtask

    task automatic go_hold(input string ph);
        do_clear();
        for (int i = 0; i < 5; i++) frame(0, 0, 800, ph);
        for (int i = 0; i < 8; i++) frame(900, 0, 0, ph);
    endtask

    initial begin
        int p0, n;
        bus.clear = 1'b0; bus.alarm_ack = 1'b0; bus.done = 1'b0;
        set_scores(0, 0, 0);

        // Reset
        Rst = 1'b1;
        step(2, "reset");
        chk("reset_state", 32'(bus.state), 0);
        chk("reset_alarm", 32'(bus.alarm), 0);
        Rst = 1'b0;
        step(1, "reset_rel");

        // Alert frames
        pulses = 0;
        for (int i = 0; i < 3; i++) frame(900, 50, 50, "t1");
        chk("t1_pulses", pulses, 3);
        chk("t1_class", 32'(bus.class_out), 0);
        chk("t1_cnt", 32'(bus.drowsy_cnt), 0);

        // Held-high done
        pulses = 0;
        set_scores(0, 0, 900);
        bus.done = 1'b1;
        step(20, "t2");
        bus.done = 1'b0;
        step(2, "t2");
        chk("t2_pulses", pulses, 1);
        chk("t2_cnt", 32'(bus.drowsy_cnt), 1);

        // Escalation
        do_clear();
        for (int i = 0; i < 3; i++) frame(0, 0, 800, "t3");
        chk("t3_warn", 32'(bus.warn), 1);
        frame(0, 0, 800, "t3");
        frame(0, 0, 800, "t3");
        chk("t3_alarm", 32'(bus.alarm), 1);
        chk("t3_cnt", 32'(bus.drowsy_cnt), 5);

        // Ack in ALARM ignored, then hold timeout
        bus.alarm_ack = 1'b1;
        step(2, "t4_ack_alarm");
        bus.alarm_ack = 1'b0;
        chk("t4_ack_alarm", 32'(bus.state), 2);
        for (int i = 0; i < 8; i++) frame(900, 0, 0, "t4");
        chk("t4_hold", 32'(bus.state), 3);
        n = 0;
        while (bus.alarm === 1'b1 && n < 20) begin
            step(1, "t4_hold");
            n++;
        end
        chk("t4_hold_len", n, HOLD_CYC);

        // Ack in HOLD
        go_hold("t4b");
        chk("t4b_hold", 32'(bus.state), 3);
        step(2, "t4b");
        bus.alarm_ack = 1'b1;
        step(1, "t4b_ack");
        bus.alarm_ack = 1'b0;
        chk("t4b_ack_state", 32'(bus.state), 0);

        // Ties, unknown run, fault stickiness
        do_clear();
        frame(700, 700, 700, "t5");
        chk("t5_tie", 32'(bus.class_out), 2);
        for (int i = 0; i < 3; i++) frame(500, 400, 300, "t5");
        chk("t5_unk", 32'(bus.class_out), 3);
        chk("t5_nofault", 32'(bus.fault), 0);
        frame(500, 400, 300, "t5");
        chk("t5_fault", 32'(bus.fault), 1);
        frame(900, 0, 0, "t5");
        chk("t5_sticky", 32'(bus.fault), 1);
        do_clear();
        chk("t5_cleared", 32'(bus.fault), 0);

        // Clear coincident with accept
        set_scores(0, 0, 900);
        bus.done = 1'b1; bus.clear = 1'b1;
        step(1, "t6");
        chk("t6_valid", 32'(bus.class_valid), 0);
        chk("t6_cnt", 32'(bus.drowsy_cnt), 0);
        chk("t6_state", 32'(bus.state), 0);
        bus.clear = 1'b0;
        p0 = pulses;
        step(3, "t6_held");
        chk("t6_no_reaccept", pulses - p0, 0);
        bus.done = 1'b0;
        step(1, "t6");

        // Asynchronous reset while in HOLD
        go_hold("t6b");
        chk("t6b_hold", 32'(bus.state), 3);
        #2;
        Rst = 1'b1;
        #1;
        check_all("t6b_rst");
        chk("t6b_rst_alarm", 32'(bus.alarm), 0);
        chk("t6b_rst_cnt", 32'(bus.drowsy_cnt), 0);
        @(negedge Clock);
        Rst = 1'b0;
        step(1, "t6b_rel");

        // Randomized frames
        for (int it = 0; it < 300; it++) begin
            int kind, hi, lo1, lo2;
            kind = $urandom_range(0, 4);
            hi   = $urandom_range(550, 1023);
            lo1  = $urandom_range(0, 600);
            lo2  = $urandom_range(0, 600);
            case (kind)
                0, 1: set_scores(lo1, lo2, hi);
                2:    set_scores(hi, lo1, lo2);
                3:    set_scores(lo1, hi, lo2);
                default: set_scores(hi, hi, ($urandom_range(0, 1) == 1) ? hi : lo1);
            endcase
            bus.alarm_ack = ($urandom_range(0, 7) == 0);
            bus.clear     = ($urandom_range(0, 39) == 0);
            bus.done      = 1'b1;
            step($urandom_range(1, 3), "rand");
            bus.clear = 1'b0;
            bus.done  = 1'b0;
            step($urandom_range(1, 3), "rand");
        end
        bus.alarm_ack = 1'b0;
        step(HOLD_CYC + 4, "rand_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
